// File: rtl/mux_handshake_receiver_mc.sv
// Multi-channel receiving end of a 4-phase req/ack CDC handshake.
// Requests are synchronised, and captured words are merged round-robin into one valid/ready stream.
module mux_handshake_receiver_mc #(
    parameter  int SYNC_STAGES = 2,
    parameter  int DATA_WIDTH  = 8,
    parameter  int CHANNELS    = 4,
    localparam int CHAN_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                           i_clk,
    input  logic                           i_arst_n,
    input  logic [CHANNELS-1:0]            i_req,
    input  logic [CHANNELS*DATA_WIDTH-1:0] i_data,
    output logic [CHANNELS-1:0]            o_ack,
    output logic                           o_valid,
    input  logic                           i_ready,
    output logic [DATA_WIDTH-1:0]          o_data,
    output logic [CHAN_W-1:0]              o_chan,
    output logic [CHANNELS-1:0]            o_err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PEND,
        ST_ACK
    } state_e;

    logic [CHANNELS-1:0]   sync_q [SYNC_STAGES];
    logic [CHANNELS-1:0]   req_s;
    state_e                state_q [CHANNELS];
    state_e                state_d [CHANNELS];
    logic [DATA_WIDTH-1:0] hold_q  [CHANNELS];
    logic [CHANNELS-1:0]   err_q, err_d;
    logic [CHANNELS-1:0]   pend;
    logic [CHAN_W-1:0]     ptr_q;
    logic                  valid_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [CHAN_W-1:0]     chan_q;
    logic                  slot_free;
    logic                  grant_valid;
    logic [CHAN_W-1:0]     grant_idx;

    // Index arithmetic modulo CHANNELS without a divider: base < CHANNELS, offset <= CHANNELS.
    function automatic logic [CHAN_W-1:0] wrap_idx(input logic [CHAN_W-1:0] base, input int offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= CHANNELS) sum = sum - CHANNELS;
        return CHAN_W'(sum);
    endfunction

    // NOTE: every clocked process uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
        end else begin
            sync_q[0] <= i_req;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

    assign req_s     = sync_q[SYNC_STAGES-1];
    assign slot_free = ~valid_q | i_ready;

    always_comb begin
        for (int c = 0; c < CHANNELS; c++) pend[c] = (state_q[c] == ST_PEND);
    end

    // Round-robin search starting at the pointer; only grants when the output slot can take a word.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        if (slot_free) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (!grant_valid && pend[wrap_idx(ptr_q, i)]) begin
                    grant_valid = 1'b1;
                    grant_idx   = wrap_idx(ptr_q, i);
                end
            end
        end
    end

    // NOTE: next-state signals get a default before the case so no path leaves them unassigned (no latches).
    always_comb begin
        err_d = err_q;
        for (int c = 0; c < CHANNELS; c++) begin
            state_d[c] = state_q[c];
            case (state_q[c])
                ST_IDLE: if (req_s[c]) state_d[c] = ST_PEND;
                ST_PEND: begin
                    // A withdrawn request is flagged, but the captured word is still delivered.
                    if (!req_s[c]) err_d[c] = 1'b1;
                    if (grant_valid && grant_idx == CHAN_W'(c)) state_d[c] = ST_ACK;
                end
                ST_ACK:  if (!req_s[c]) state_d[c] = ST_IDLE;
                default: state_d[c] = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            for (int c = 0; c < CHANNELS; c++) begin
                state_q[c] <= ST_IDLE;
                hold_q[c]  <= '0;
            end
            err_q <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                state_q[c] <= state_d[c];
                // i_data is sampled only once req_s is high, so the sender guarantees it is stable.
                if (state_q[c] == ST_IDLE && req_s[c]) hold_q[c] <= i_data[c*DATA_WIDTH +: DATA_WIDTH];
            end
            err_q <= err_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            chan_q  <= '0;
            ptr_q   <= '0;
        end else if (slot_free) begin
            if (grant_valid) begin
                valid_q <= 1'b1;
                data_q  <= hold_q[grant_idx];
                chan_q  <= grant_idx;
                ptr_q   <= wrap_idx(grant_idx, 1);
            end else begin
                valid_q <= 1'b0;
            end
        end
    end

    always_comb begin
        for (int c = 0; c < CHANNELS; c++) o_ack[c] = (state_q[c] == ST_ACK);
    end

    assign o_valid = valid_q;
    assign o_data  = data_q;
    assign o_chan  = chan_q;
    assign o_err   = err_q;

endmodule

// File: tb/tb_mux_handshake_receiver_mc.sv
// Directed self-checking bench for mux_handshake_receiver_mc (CHANNELS=4, SYNC_STAGES=2).
module tb_mux_handshake_receiver_mc;

    localparam int SYNC_STAGES = 2;
    localparam int DATA_WIDTH  = 8;
    localparam int CHANNELS    = 4;

    logic        clk = 1'b0;
    logic        arst_n;
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  ack;
    logic        valid;
    logic        ready;
    logic [7:0]  odata;
    logic [1:0]  ochan;
    logic [3:0]  err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mux_handshake_receiver_mc #(
        .SYNC_STAGES(SYNC_STAGES),
        .DATA_WIDTH (DATA_WIDTH),
        .CHANNELS   (CHANNELS)
    ) dut (
        .i_clk   (clk),
        .i_arst_n(arst_n),
        .i_req   (req),
        .i_data  (data),
        .o_ack   (ack),
        .o_valid (valid),
        .i_ready (ready),
        .o_data  (odata),
        .o_chan  (ochan),
        .o_err   (err)
    );

    // Inputs change and outputs are sampled on the falling edge, away from the active edge.
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        arst_n = 1'b0;
        req    = '0;
        data   = '0;
        tick(2);
        arst_n = 1'b1;
    endtask

    task automatic test_reset();
        arst_n = 1'b0;
        req    = '0;
        data   = '0;
        ready  = 1'b1;
        tick(2);
        n_checks++;
        if ({valid, ochan, odata, ack, err} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b ch=%0d d=%h ack=%b err=%b, want all zero",
                     valid, ochan, odata, ack, err);
        end
        arst_n = 1'b1;
        tick(2);
        n_checks++;
        if ({valid, ack} !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_idle: got v=%b ack=%b, want 0/0000", valid, ack);
        end
    endtask

    task automatic test_single();
        do_reset();
        ready = 1'b1;
        data[2*8 +: 8] = 8'hA5;
        req[2] = 1'b1;
        tick(3);
        n_checks++;
        if ({valid, ack} !== 5'd0) begin
            n_fail++;
            $display("FAIL single_pend: got v=%b ack=%b after 3 edges, want 0/0000", valid, ack);
        end
        tick(1);
        n_checks++;
        if ({valid, ochan, odata, ack} !== {1'b1, 2'd2, 8'hA5, 4'b0100}) begin
            n_fail++;
            $display("FAIL single_out: got v=%b ch=%0d d=%h ack=%b, want v=1 ch=2 d=a5 ack=0100",
                     valid, ochan, odata, ack);
        end
        req[2] = 1'b0;
        tick(1);
        n_checks++;
        if (valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_valid_drop: got v=%b, want 0", valid);
        end
        tick(1);
        n_checks++;
        if (ack !== 4'b0100) begin
            n_fail++;
            $display("FAIL single_ack_hold: got ack=%b two edges after drop, want 0100", ack);
        end
        tick(1);
        n_checks++;
        if (ack !== 4'b0000) begin
            n_fail++;
            $display("FAIL single_ack_fall: got ack=%b three edges after drop, want 0000", ack);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        ready = 1'b1;
        data  = {8'h13, 8'h12, 8'h11, 8'h10};
        req   = 4'b1111;
        tick(3);
        for (int i = 0; i < 4; i++) begin
            tick(1);
            n_checks++;
            if ({valid, ochan, odata} !== {1'b1, 2'(i), 8'(8'h10 + i)}) begin
                n_fail++;
                $display("FAIL rr_word%0d: got v=%b ch=%0d d=%h, want v=1 ch=%0d d=%h",
                         i, valid, ochan, odata, i, 8'h10 + i);
            end
        end
        n_checks++;
        if (ack !== 4'b1111) begin
            n_fail++;
            $display("FAIL rr_ack_all: got ack=%b, want 1111", ack);
        end
        req = 4'b0000;
        tick(1);
        n_checks++;
        if (valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rr_idle: got v=%b, want 0", valid);
        end
        tick(2);
        n_checks++;
        if (ack !== 4'b0000) begin
            n_fail++;
            $display("FAIL rr_ack_release: got ack=%b, want 0000", ack);
        end
        data = {8'h23, 8'h00, 8'h00, 8'h20};
        req  = 4'b1001;
        tick(4);
        n_checks++;
        if ({valid, ochan, odata} !== {1'b1, 2'd0, 8'h20}) begin
            n_fail++;
            $display("FAIL rr_rereq_first: got v=%b ch=%0d d=%h, want v=1 ch=0 d=20", valid, ochan, odata);
        end
        tick(1);
        n_checks++;
        if ({valid, ochan, odata, ack} !== {1'b1, 2'd3, 8'h23, 4'b1001}) begin
            n_fail++;
            $display("FAIL rr_rereq_second: got v=%b ch=%0d d=%h ack=%b, want v=1 ch=3 d=23 ack=1001",
                     valid, ochan, odata, ack);
        end
        req = 4'b0000;
        tick(4);
    endtask

    task automatic test_backpressure();
        do_reset();
        ready = 1'b0;
        data  = {8'h00, 8'h32, 8'h31, 8'h00};
        req   = 4'b0110;
        tick(3);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            n_checks++;
            if ({valid, ochan, odata, ack} !== {1'b1, 2'd1, 8'h31, 4'b0010}) begin
                n_fail++;
                $display("FAIL bp_stall%0d: got v=%b ch=%0d d=%h ack=%b, want v=1 ch=1 d=31 ack=0010",
                         i, valid, ochan, odata, ack);
            end
        end
        ready = 1'b1;
        tick(1);
        n_checks++;
        if ({valid, ochan, odata, ack} !== {1'b1, 2'd2, 8'h32, 4'b0110}) begin
            n_fail++;
            $display("FAIL bp_release: got v=%b ch=%0d d=%h ack=%b, want v=1 ch=2 d=32 ack=0110",
                     valid, ochan, odata, ack);
        end
        req = 4'b0000;
        tick(4);
    endtask

    task automatic test_protocol_violation();
        do_reset();
        ready = 1'b0;
        data  = {8'h43, 8'h00, 8'h00, 8'h40};
        req   = 4'b1001;
        tick(4);
        req[3] = 1'b0;
        tick(2);
        n_checks++;
        if (err !== 4'b0000) begin
            n_fail++;
            $display("FAIL pv_err_early: got err=%b before req_s falls, want 0000", err);
        end
        tick(2);
        n_checks++;
        if ({valid, ochan, odata, ack, err} !== {1'b1, 2'd0, 8'h40, 4'b0001, 4'b1000}) begin
            n_fail++;
            $display("FAIL pv_flag: got v=%b ch=%0d d=%h ack=%b err=%b, want v=1 ch=0 d=40 ack=0001 err=1000",
                     valid, ochan, odata, ack, err);
        end
        ready = 1'b1;
        tick(1);
        n_checks++;
        if ({valid, ochan, odata, ack} !== {1'b1, 2'd3, 8'h43, 4'b1001}) begin
            n_fail++;
            $display("FAIL pv_deliver: got v=%b ch=%0d d=%h ack=%b, want v=1 ch=3 d=43 ack=1001",
                     valid, ochan, odata, ack);
        end
        tick(1);
        n_checks++;
        if ({valid, ack, err} !== {1'b0, 4'b0001, 4'b1000}) begin
            n_fail++;
            $display("FAIL pv_pulse_end: got v=%b ack=%b err=%b, want v=0 ack=0001 err=1000",
                     valid, ack, err);
        end
        req = 4'b0000;
        tick(4);
        n_checks++;
        if (err !== 4'b1000) begin
            n_fail++;
            $display("FAIL pv_sticky: got err=%b, want 1000", err);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        ready = 1'b1;
        data  = {8'h00, 8'h00, 8'h51, 8'h50};
        req   = 4'b0011;
        tick(5);
        n_checks++;
        if ({valid, ochan, odata, ack} !== {1'b1, 2'd1, 8'h51, 4'b0011}) begin
            n_fail++;
            $display("FAIL rm_before: got v=%b ch=%0d d=%h ack=%b, want v=1 ch=1 d=51 ack=0011",
                     valid, ochan, odata, ack);
        end
        #2 arst_n = 1'b0;
        #1;
        n_checks++;
        if ({valid, ochan, odata, ack, err} !== 19'd0) begin
            n_fail++;
            $display("FAIL rm_async: got v=%b ch=%0d d=%h ack=%b err=%b, want all zero",
                     valid, ochan, odata, ack, err);
        end
        tick(1);
        arst_n = 1'b1;
        tick(4);
        n_checks++;
        if ({valid, ochan, odata, ack} !== {1'b1, 2'd0, 8'h50, 4'b0001}) begin
            n_fail++;
            $display("FAIL rm_first: got v=%b ch=%0d d=%h ack=%b, want v=1 ch=0 d=50 ack=0001",
                     valid, ochan, odata, ack);
        end
        tick(1);
        n_checks++;
        if ({valid, ochan, odata, ack} !== {1'b1, 2'd1, 8'h51, 4'b0011}) begin
            n_fail++;
            $display("FAIL rm_second: got v=%b ch=%0d d=%h ack=%b, want v=1 ch=1 d=51 ack=0011",
                     valid, ochan, odata, ack);
        end
        req = 4'b0000;
        tick(4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        arst_n = 1'b0;
        req    = '0;
        data   = '0;
        ready  = 1'b1;
        tick(1);
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_protocol_violation();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_handshake_receiver_mc.md
Name: mux_handshake_receiver_mc

Overview:
Multi-channel, single-clock receiving end of a 4-phase req/ack handshake CDC.
- Each of CHANNELS foreign-domain senders drives a level request plus a data word that is held stable while the request is high.
- The block synchronises each request and captures the data with a recirculating mux register.
- It merges all channels into one valid/ready output stream under round-robin arbitration, with downstream backpressure.
- Per-channel acknowledges are returned as registered levels, which the sender synchronises back into its own domain.

Parameters:
SYNC_STAGES, 2, flip-flop stages per request synchroniser (>=2).
DATA_WIDTH, 8, bits per channel data word.
CHANNELS, 4, number of independent handshake channels (>=1).
CHAN_W, derived: max(1, clog2(CHANNELS)); localparam, not overridable.

Ports:
i_clk  in  1  receiving-domain clock.
i_arst_n  in  1  asynchronous active-low reset.
i_req  in  CHANNELS  asynchronous request levels, one per channel.
i_data  in  CHANNELS*DATA_WIDTH  channel c occupies bits [c*DATA_WIDTH +: DATA_WIDTH]; stable while i_req[c]=1.
o_ack  out  CHANNELS  registered acknowledge levels back to the senders.
o_valid  out  1  output word valid.
i_ready  in  1  downstream accepts the word when o_valid & i_ready.
o_data  out  DATA_WIDTH  output data word.
o_chan  out  CHAN_W  source channel index of o_data.
o_err  out  CHANNELS  sticky protocol-violation flag per channel.

Behaviour:
- Reset (async assert, sync release):
  - All channel FSMs go to IDLE.
  - o_ack=0, o_valid=0, o_data=0, o_chan=0, o_err=0.
  - Round-robin pointer=0.
  - Synchroniser stages=0.
- Synchronisation: req_s[c] is i_req[c] delayed through SYNC_STAGES flops. Only req_s is used internally; i_data is sampled only when req_s=1, which guarantees stability.
- Per-channel FSM, states IDLE, PEND, ACK:
  - IDLE & req_s=1 -> PEND. At that edge, hold[c] <= i_data slice. Otherwise hold[c] recirculates.
  - PEND & granted -> ACK.
  - ACK & req_s=0 -> IDLE. ACK & req_s=1 -> stay in ACK.
  - o_ack[c] = (state==ACK), decoded from the state register, so it is glitch-free.
- Output slot:
  - The slot is free when ~o_valid | i_ready.
  - When the slot is free and any channel is in PEND, grant the first PEND channel found searching from the pointer upward, modulo CHANNELS.
  - At the grant edge: o_valid<=1, o_data<=hold[g], o_chan<=g, pointer<=(g+1) mod CHANNELS, channel g -> ACK.
  - Slot free with no PEND channel: o_valid<=0.
  - Not free: all output registers hold.
- Latency:
  - i_req rise -> PEND after SYNC_STAGES+1 edges.
  - Uncontended and slot free: o_valid and o_ack rise on the next edge.
  - o_ack falls one edge after req_s falls.
- Throughput: one word per cycle when i_ready is held high; accept and new grant occur in the same cycle.
- Backpressure: while o_valid & ~i_ready, all PEND channels keep pending and no ack is raised. Senders therefore stall naturally.
- Protocol violation: req_s falls while a channel is in PEND (sender withdrew before ack).
  - o_err[c]<=1 (sticky until reset).
  - The captured word is still delivered.
  - After the grant the channel enters ACK and leaves it the next cycle, producing a one-cycle ack pulse.
- A request already high at reset release is captured normally once synchronised.
- CHANNELS=1: the pointer stays 0 and o_chan=0.
- Fairness: a channel in PEND is granted within CHANNELS free-slot cycles.

Test Plan:
- Single transfer: CHANNELS=4, SYNC_STAGES=2, i_ready=1; raise i_req[2] with data 8'hA5.
  -> o_valid=1, o_data=A5, o_chan=2, o_ack[2]=1 on edge 4 after req.
  -> Drop i_req[2]: o_ack[2]=0 three edges later.
- Round robin: all four requests rise in the same cycle with data 10,11,12,13, i_ready=1.
  -> Outputs in consecutive cycles, chan 0,1,2,3.
  -> Re-request channels 0 and 3 after ack release: order 0,3.
- Backpressure: hold i_ready=0 with channels 1 and 2 pending.
  -> o_valid=1 with chan 1 held stable; o_ack[2] stays 0.
  -> Release i_ready: chan 2 is delivered next cycle and o_ack[2] rises.
- Protocol violation: drop i_req[3] while it is PEND behind a stalled output.
  -> o_err[3]=1; word still delivered; o_ack[3] pulses high for one cycle.
- Reset mid-operation: assert i_arst_n=0 with o_valid=1 and two channels in ACK.
  -> All outputs 0 immediately.
  -> After release with i_req still high: channels are re-captured and delivered in order 0-first.
